// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with load, edge-detected decrement and expiry pulse.
// Optional build macro COUNTDOWN_WRAP_EN: a decrement in DONE wraps the count to all 9s and re-enters RUN.

module bcd_cd_digit (
  input  logic [3:0] d,
  input  logic [3:0] ld,
  output logic [3:0] dm1,
  output logic [3:0] ld_clamp,
  output logic       is_zero
);
  assign dm1      = (d == 4'd0) ? 4'd9 : d - 4'd1;
  assign ld_clamp = (ld > 4'd9) ? 4'd9 : ld;
  assign is_zero  = (d == 4'd0);
endmodule

module bcd_countdown #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_value,
  input  logic              dec,
  output logic [4*NDIG-1:0] digits,
  output logic              zero,
  output logic              running,
  output logic              expired
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [NDIG-1:0][3:0]  cnt, cnt_nxt, cnt_dec, ld_c, dm1, lv;
  logic [NDIG-1:0]       dz;
  logic [NDIG:0]         low_zero;
  logic                  dec_q, dec_p, exp_nxt;

  assign lv    = load_value;
  assign dec_p = dec & ~dec_q;

  // low_zero[i]: every digit below i is 0, so digit i takes the borrow.
  assign low_zero[0] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_cd_digit u_dig (
      .d(cnt[i]), .ld(lv[i]), .dm1(dm1[i]), .ld_clamp(ld_c[i]), .is_zero(dz[i])
    );
    assign low_zero[i+1] = low_zero[i] & dz[i];
    assign cnt_dec[i]    = low_zero[i] ? dm1[i] : cnt[i];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exp_nxt   = 1'b0;
    if (load) begin
      cnt_nxt   = ld_c;
      state_nxt = (ld_c == '0) ? DONE : RUN;
    end else begin
      case (state)
        RUN: if (dec_p) begin
          cnt_nxt = cnt_dec;
          if (cnt_dec == '0) begin
            state_nxt = DONE;
            exp_nxt   = 1'b1;
          end
        end
`ifdef COUNTDOWN_WRAP_EN
        // Decrementing an all-zero count borrows through every digit: 0..0 -> 9..9.
        DONE: if (dec_p) begin
          cnt_nxt   = cnt_dec;
          state_nxt = RUN;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dec_q   <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dec_q   <= dec;
      expired <= exp_nxt;
    end
  end

  assign digits  = cnt;
  assign zero    = low_zero[NDIG];
  assign running = (state == RUN);
endmodule
